imem_loader: RTL
================

# imem_loader

Program loader that writes a byte-serial program image into the instruction memory ahead of the single-cycle datapath. It is the writer on the memory port that the datapath only reads. It accepts a length-prefixed byte stream over a valid/ready handshake, packs the bytes big-endian into 32-bit MIPS words, and issues one-cycle word writes at consecutive byte addresses. While loading, it holds the CPU with `cpu_hold`; it releases the CPU when the image is complete.

## Interface
- `ADDR_WIDTH`, default 8: log2 of instruction-memory capacity in words (capacity = 2^ADDR_WIDTH words).
- `BASE_ADDR`, default 32'h0: byte address of the first word written; must be word aligned.

- `clock`, input, 1: the single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset. `reset`=0 forces the reset state immediately.
- `start`, input, 1: one-cycle request to begin a load. Honoured only in IDLE, DONE or ERROR.
- `in_data`, input, 8: stream byte.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: loader accepts a byte this cycle.
- `mem_we`, output, 1: instruction-memory write strobe, one cycle per word.
- `mem_addr`, output, 32: byte address of the write.
- `mem_wdata`, output, 32: word to write.
- `busy`, output, 1: a load is in progress.
- `done`, output, 1: last load completed; sticky.
- `error`, output, 1: last load rejected because the length exceeded capacity; sticky.
- `cpu_hold`, output, 1: high holds the datapath PC and register writes.

## Operation
- Stream format:
  - Byte 0 is `len[15:8]`; byte 1 is `len[7:0]`, giving the word count N.
  - These are followed by 4·N data bytes, most-significant byte first within each word.
- A byte is consumed on a rising edge where `in_valid` and `in_ready` are both 1. Bytes offered while `in_ready`=0 are not consumed, and the source holds them.
- States:
  - IDLE → LEN_HI on `start`.
  - LEN_HI: consume byte → `len[15:8]`, go to LEN_LO.
  - LEN_LO: consume byte → `len[7:0]`.
    - If N=0, go to DONE.
    - Else if N > 2^ADDR_WIDTH, go to ERROR.
    - Else clear the word index and byte count, go to DATA.
  - DATA: shift each consumed byte into `mem_wdata` (`wdata <= {wdata[23:0], byte}`). On the 4th byte, go to WRITE.
  - WRITE: `mem_we`=1 for exactly one cycle. The index then increments.
    - If the index was N−1, go to DONE.
    - Otherwise go to DATA with the byte count cleared.
  - DONE: hold until `start`, which clears `done` and goes to LEN_HI.
  - ERROR: hold until `start`, which clears `error` and goes to LEN_HI.
- `in_ready`=1 only in LEN_HI, LEN_LO and DATA. It is a decode of the state register and has no combinational path from `in_valid`.
- `busy`=1 in LEN_HI, LEN_LO, DATA and WRITE.
- `cpu_hold`=1 in every state except DONE.
- `done` is set on entry to DONE. `error` is set on entry to ERROR.
- Address: `mem_addr` = BASE_ADDR + {index, 2'b00}. The index is ADDR_WIDTH+1 bits wide, so N = 2^ADDR_WIDTH is legal. The addition is 32-bit and truncates silently.
- `start` in LEN_HI, LEN_LO, DATA or WRITE is ignored.
- No writes are ever issued for an ERROR or N=0 load.

## Timing
- Reset values: state IDLE, `in_ready`=0, `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0, `busy`=0, `done`=0, `error`=0, `cpu_hold`=1. Length, index and byte count are 0.
- Reset asserted mid-load abandons the load immediately. Writes already issued remain in memory. No partial word is written.
- `start` sampled on edge t: `in_ready`=1 after edge t.
- 4th data byte consumed at edge t: `mem_we`=1 during cycle t→t+1, with `mem_addr` and `mem_wdata` stable for that cycle. Memory captures on edge t+1.
- `in_ready` is 0 during WRITE. The minimum rate is 5 cycles per word with `in_valid` held high.
- A full N-word load with continuous `in_valid` takes 1 (start) + 2 + 5N cycles. `done` and `cpu_hold`=0 appear the cycle after the last WRITE.
- `mem_we` never asserts in any state other than WRITE.

## Test plan
- Reset: drive `reset`=0 asynchronously mid-cycle → all outputs take reset values without waiting for a clock edge. `cpu_hold`=1, `in_ready`=0.
- Continuous load:
  - Stimulus: `start`, then bytes 00 02 8C 01 00 04 00 22 18 20 with `in_valid` held high.
  - Required: two `mem_we` pulses, addr 0x0 data 0x8C010004 and addr 0x4 data 0x00221820.
  - Required: `done`=1 and `cpu_hold`=0 exactly 13 cycles after `start`.
- Throttled load: same image with `in_valid` toggled pseudo-randomly → identical writes, with no byte lost or duplicated. `mem_we` count = 2.
- Zero length: bytes 00 00 → DONE with no `mem_we`, and `in_ready`=0 afterwards.
- Over-capacity with ADDR_WIDTH=8: length 01 01 (N=257) → `error`=1 and `cpu_hold`=1 with no `mem_we`. A following `start` clears `error` and accepts a valid image. Length 01 00 (N=256) completes with the last address 0x3FC.
- Interference:
  - `start` pulsed during DATA → ignored, load completes normally.
  - `reset`=0 after 2 of 4 bytes of word 1 → no write of word 1.
  - After reset release and a new `start`, a fresh image loads from BASE_ADDR.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the program loader.
// The loader is the master: it consumes the stream and drives the memory writes.
interface imem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed, big-endian byte stream into instruction memory as 32-bit
// word writes, holding the CPU until the image is complete.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          cpu_hold
);

    localparam int unsigned INDEX_W  = ADDR_WIDTH + 1;
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR
    } state_t;

    typedef struct packed {
        logic in_ready;
        logic busy;
        logic cpu_hold;
        logic mem_we;
    } flags_t;

    // Output flags are a pure function of the state being entered, so they are
    // loaded alongside the state register and never depend on in_valid.
    function automatic flags_t flags_for(state_t s);
        flags_t f;
        f.in_ready = (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA);
        f.busy     = f.in_ready || (s == S_WRITE);
        f.cpu_hold = (s != S_DONE);
        f.mem_we   = (s == S_WRITE);
        return f;
    endfunction

    state_t             state;
    flags_t             flags;
    logic [15:0]        len;
    logic [INDEX_W-1:0] index;
    logic [1:0]         byte_cnt;
    logic [31:0]        wdata;

    logic        take;
    logic [15:0] len_next;

    assign take     = bus.in_valid & flags.in_ready;
    assign len_next = {len[15:8], bus.in_data};

    // NOTE: every register below uses non-blocking assignment, so all branches of
    // the case read the pre-edge values and the update order inside the block is moot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            flags    <= flags_for(S_IDLE);
            len      <= '0;
            index    <= '0;
            byte_cnt <= '0;
            wdata    <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    state <= S_LEN_HI;
                    flags <= flags_for(S_LEN_HI);
                end
                S_LEN_HI: if (take) begin
                    len[15:8] <= bus.in_data;
                    state     <= S_LEN_LO;
                    flags     <= flags_for(S_LEN_LO);
                end
                S_LEN_LO: if (take) begin
                    len[7:0] <= bus.in_data;
                    if (len_next == 16'd0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                        flags <= flags_for(S_DONE);
                    end else if ({16'd0, len_next} > CAPACITY) begin
                        error <= 1'b1;
                        state <= S_ERROR;
                        flags <= flags_for(S_ERROR);
                    end else begin
                        index    <= '0;
                        byte_cnt <= '0;
                        state    <= S_DATA;
                        flags    <= flags_for(S_DATA);
                    end
                end
                S_DATA: if (take) begin
                    wdata    <= {wdata[23:0], bus.in_data};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        state <= S_WRITE;
                        flags <= flags_for(S_WRITE);
                    end
                end
                S_WRITE: begin
                    index <= index + INDEX_W'(1);
                    if (32'(index) + 32'd1 == {16'd0, len}) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                        flags <= flags_for(S_DONE);
                    end else begin
                        byte_cnt <= '0;
                        state    <= S_DATA;
                        flags    <= flags_for(S_DATA);
                    end
                end
                S_DONE: if (start) begin
                    done  <= 1'b0;
                    state <= S_LEN_HI;
                    flags <= flags_for(S_LEN_HI);
                end
                S_ERROR: if (start) begin
                    error <= 1'b0;
                    state <= S_LEN_HI;
                    flags <= flags_for(S_LEN_HI);
                end
                default: begin
                    state <= S_IDLE;
                    flags <= flags_for(S_IDLE);
                end
            endcase
        end
    end

    assign bus.in_ready  = flags.in_ready;
    assign bus.mem_we    = flags.mem_we;
    assign bus.mem_wdata = wdata;
    assign bus.mem_addr  = BASE_ADDR + 32'({index, 2'b00});
    assign busy          = flags.busy;
    assign cpu_hold      = flags.cpu_hold;

endmodule
